// File: rtl/queue_ctrl_pkg.sv
// Shared definitions for the byte-queue path: default widths and the drain sequencer states.
package queue_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_LEN_W  = 4;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_THRESH = 4;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    SETTLE,
    PRESENT
  } drain_state_t;

endpackage

// File: rtl/queue_drain_ctrl_if.sv
// Queue-side and consumer-side signals of the drain sequencer.
interface queue_drain_ctrl_if
  import queue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
);

  logic [LEN_W-1:0]  q_len_in;
  logic [DATA_W-1:0] q_data_in;
  logic              q_dequeue_out;
  logic [DATA_W-1:0] m_data_out;
  logic              m_valid_out;
  logic              m_ready_in;

  // master = the drain sequencer, slave = queue plus consumer
  modport master (
    input  q_len_in, q_data_in, m_ready_in,
    output q_dequeue_out, m_data_out, m_valid_out
  );

  modport slave (
    output q_len_in, q_data_in, m_ready_in,
    input  q_dequeue_out, m_data_out, m_valid_out
  );

endinterface

// File: rtl/queue_drain_ctrl.sv
// Drains the deserializer byte queue in threshold/flush-triggered bursts and
// presents each popped byte to the consumer over valid/ready.
module queue_drain_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned THRESH = DEF_THRESH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_in,
  input  logic               flush_in,
  queue_drain_ctrl_if.master bus,
  output logic               busy_out,
  output logic               full_out
);

  if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
    $error("queue_drain_ctrl: THRESH must lie in 1..DEPTH");
  end

  if (DEPTH >= (1 << LEN_W)) begin : g_bad_len_w
    $error("queue_drain_ctrl: LEN_W too narrow to count DEPTH entries");
  end

  drain_state_t      state;
  logic              burst;
  logic              deq_q;
  logic              valid_q;
  logic              busy_q;
  logic [DATA_W-1:0] data_q;

  logic [LEN_W-1:0]  len;
  logic              have_data;
  logic              start;
  logic              handshake;

  assign len       = bus.q_len_in;
  assign have_data = (len != '0);
  // THRESH >= 1, so the threshold term alone already implies a non-empty queue
  assign start     = (enable_in && (len >= LEN_W'(THRESH))) || (flush_in && have_data);
  assign handshake = valid_q && bus.m_ready_in;

  // Sequencer: every pop is gated by a non-empty check made on the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      burst   <= 1'b0;
      deq_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      deq_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            burst  <= 1'b1;
            state  <= POP;
            deq_q  <= 1'b1;
            busy_q <= 1'b1;
            data_q <= bus.q_data_in;
          end
        end
        POP: begin
          state <= SETTLE;
        end
        SETTLE: begin
          state   <= PRESENT;
          valid_q <= 1'b1;
        end
        PRESENT: begin
          if (handshake) begin
            valid_q <= 1'b0;
            if (burst && have_data) begin
              state  <= POP;
              deq_q  <= 1'b1;
              data_q <= bus.q_data_in;
            end else begin
              burst  <= 1'b0;
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          burst  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q_dequeue_out = deq_q;
  assign bus.m_valid_out   = valid_q;
  assign bus.m_data_out    = data_q;
  assign busy_out          = busy_q;
  assign full_out          = (len == LEN_W'(DEPTH));

endmodule

// File: tb/tb_queue_drain_ctrl.sv
// Directed bench for queue_drain_ctrl: a behavioural queue drives the DUT, a
// per-cycle timing/scoreboard model checks it, and per-phase literals pin the model.
module tb_queue_drain_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned THRESH = 4;
  localparam int unsigned NPH    = 11;
  localparam int unsigned NLOG   = 16;

  logic clock = 1'b0;
  logic reset;
  logic enable_in;
  logic flush_in;
  logic busy_out;
  logic full_out;

  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  int unsigned       phase;
  logic              done;
  logic              timeout_flag;

  queue_drain_ctrl_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  queue_drain_ctrl #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .THRESH(THRESH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable_in (enable_in),
    .flush_in  (flush_in),
    .bus       (bus),
    .busy_out  (busy_out),
    .full_out  (full_out)
  );

  always #5 clock = ~clock;

  // Behavioural saturating queue; it keeps its contents across DUT reset
  logic [DATA_W-1:0] fifo [$];
  always @(posedge clock) begin
    if (bus.q_dequeue_out && fifo.size() > 0) void'(fifo.pop_front());
    if (wr_req && fifo.size() < int'(DEPTH)) fifo.push_back(wr_data);
    bus.q_len_in  <= LEN_W'(fifo.size());
    bus.q_data_in <= (fifo.size() > 0) ? fifo[0] : '0;
  end

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model state: what the previous cycle looked like in protocol terms
  logic              md1 = 1'b0, md2 = 1'b0, mv = 1'b0, mb = 1'b0;
  logic              p_rst = 1'b1, p_en = 1'b0, p_flush = 1'b0, p_ready = 1'b0;
  int unsigned       p_len = 0;
  logic [DATA_W-1:0] p_head = '0;
  logic [DATA_W-1:0] exp_bytes [$];

  int unsigned       last_phase = 0;
  int unsigned       phase_start [NPH] = '{default: 0};
  int unsigned       pulse_n [NPH] = '{default: 0};
  int unsigned       pc [NPH][NLOG] = '{default: '{default: 0}};
  int unsigned       hs_n [NPH] = '{default: 0};
  logic [DATA_W-1:0] hs_by [NPH][NLOG] = '{default: '{default: '0}};
  logic              fv_seen [NPH] = '{default: 1'b0};
  int unsigned       fv_cyc [NPH] = '{default: 0};
  logic [DATA_W-1:0] fv_data [NPH] = '{default: '0};
  logic              snap_busy [NPH] = '{default: 1'b0};
  logic              snap_full [NPH] = '{default: 1'b0};
  logic              snap_valid [NPH] = '{default: 1'b0};
  int unsigned       snap_len [NPH] = '{default: 0};
  logic [DATA_W-1:0] snap_data [NPH] = '{default: '0};

  task automatic check_seq(input string name, input int unsigned ph, input logic [7:0] first,
                           input logic [7:0] stp, input int unsigned n);
    logic [7:0] e;
    check({name, "_count"}, 32'(hs_n[ph]), 32'(n));
    e = first;
    for (int i = 0; i < int'(n); i++) begin
      check(name, 32'(hs_by[ph][i]), 32'(e));
      e = e + stp;
    end
  endtask

  task automatic final_checks();
    check("p1_pulses", 32'(pulse_n[1]), 32'd0);
    check("p1_busy", 32'(snap_busy[1]), 32'd0);
    check("p1_len", 32'(snap_len[1]), 32'd3);
    check("p2_pulses", 32'(pulse_n[2]), 32'd4);
    check("p2_pop_latency", 32'(pc[2][0] - phase_start[2]), 32'd2);
    check("p2_valid_latency", 32'(fv_cyc[2] - pc[2][0]), 32'd2);
    check("p2_first_data", 32'(fv_data[2]), 32'h99);
    for (int i = 1; i < 4; i++) check("p2_pulse_gap", 32'(pc[2][i] - pc[2][i-1]), 32'd3);
    check("p2_hs_count", 32'(hs_n[2]), 32'd4);
    check("p2_byte0", 32'(hs_by[2][0]), 32'h99);
    check("p2_byte1", 32'(hs_by[2][1]), 32'h3C);
    check("p2_byte2", 32'(hs_by[2][2]), 32'hA5);
    check("p2_byte3", 32'(hs_by[2][3]), 32'h0F);
    check("p2_busy_end", 32'(snap_busy[2]), 32'd0);
    check("p2_len_end", 32'(snap_len[2]), 32'd0);
    check("p3_pulses", 32'(pulse_n[3]), 32'd2);
    check_seq("p3_bytes", 3, 8'h11, 8'h11, 2);
    check("p3_len_end", 32'(snap_len[3]), 32'd0);
    check("p4_pulses", 32'(pulse_n[4]), 32'd1);
    check("p4_full", 32'(snap_full[4]), 32'd1);
    check("p4_valid_held", 32'(snap_valid[4]), 32'd1);
    check("p4_data_held", 32'(snap_data[4]), 32'h40);
    check("p4_len", 32'(snap_len[4]), 32'd8);
    check("p5_pulses", 32'(pulse_n[5]), 32'd8);
    check_seq("p5_bytes", 5, 8'h40, 8'h01, 9);
    check("p5_len_end", 32'(snap_len[5]), 32'd0);
    check("p5_busy_end", 32'(snap_busy[5]), 32'd0);
    check("p6_pulses", 32'(pulse_n[6]), 32'd1);
    check("p6_len", 32'(snap_len[6]), 32'd5);
    check("p6_valid", 32'(snap_valid[6]), 32'd1);
    check("p7_pulses", 32'(pulse_n[7]), 32'd0);
    check("p7_valid", 32'(snap_valid[7]), 32'd0);
    check("p7_busy", 32'(snap_busy[7]), 32'd0);
    check("p7_hs_count", 32'(hs_n[7]), 32'd0);
    check("p8_pop_latency", 32'(pc[8][0] - phase_start[8]), 32'd1);
    check("p8_pulses", 32'(pulse_n[8]), 32'd5);
    check_seq("p8_bytes", 8, 8'h51, 8'h01, 5);
    check("p9_pulses", 32'(pulse_n[9]), 32'd0);
    check("p9_len", 32'(snap_len[9]), 32'd8);
    check("p9_full", 32'(snap_full[9]), 32'd1);
    check("p10_pulses", 32'(pulse_n[10]), 32'd8);
    check_seq("p10_bytes", 10, 8'h60, 8'h01, 8);
    check("p10_len_end", 32'(snap_len[10]), 32'd0);
    check("p10_busy_end", 32'(snap_busy[10]), 32'd0);
    check("wait_present", 32'(timeout_flag), 32'd0);
  endtask

  // Per-cycle compare, sampled mid-cycle
  always @(negedge clock) begin
    logic        e_deq, e_valid, e_busy, hs_prev;
    int unsigned len;
    cyc++;
    len = int'(bus.q_len_in);
    if (phase != last_phase) begin
      phase_start[phase] = cyc;
      last_phase = phase;
    end
    if (reset) begin
      check("rst_dequeue", 32'(bus.q_dequeue_out), 32'd0);
      check("rst_valid", 32'(bus.m_valid_out), 32'd0);
      check("rst_busy", 32'(busy_out), 32'd0);
      check("rst_data", 32'(bus.m_data_out), 32'd0);
      exp_bytes.delete();
      md1 = 1'b0; md2 = 1'b0; mv = 1'b0; mb = 1'b0; p_rst = 1'b1;
    end else begin
      hs_prev = mv && p_ready;
      if (p_rst)        e_deq = 1'b0;
      else if (!mb)     e_deq = (p_en && p_len >= THRESH) || (p_flush && p_len > 0);
      else if (hs_prev) e_deq = (p_len > 0);
      else              e_deq = 1'b0;
      e_valid = md2 || (mv && !p_ready);
      e_busy  = e_deq || e_valid || md1;
      check("dequeue", 32'(bus.q_dequeue_out), 32'(e_deq));
      check("valid", 32'(bus.m_valid_out), 32'(e_valid));
      check("busy", 32'(busy_out), 32'(e_busy));
      check("full", 32'(full_out), 32'(len == DEPTH));
      if (bus.q_dequeue_out) check("pop_nonempty", 32'(len > 0), 32'd1);
      if (e_deq) exp_bytes.push_back(p_head);
      if (e_valid) begin
        if (exp_bytes.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
        else begin
          check("m_data", 32'(bus.m_data_out), 32'(exp_bytes[0]));
          if (bus.m_ready_in) void'(exp_bytes.pop_front());
        end
      end
      md2 = md1; md1 = e_deq; mv = e_valid; mb = e_busy; p_rst = 1'b0;
    end
    p_en = enable_in; p_flush = flush_in; p_len = len;
    p_ready = bus.m_ready_in; p_head = bus.q_data_in;

    if (bus.q_dequeue_out) begin
      if (pulse_n[phase] < NLOG) pc[phase][pulse_n[phase]] = cyc;
      pulse_n[phase]++;
    end
    if (bus.m_valid_out && bus.m_ready_in) begin
      if (hs_n[phase] < NLOG) hs_by[phase][hs_n[phase]] = bus.m_data_out;
      hs_n[phase]++;
    end
    if (bus.m_valid_out && !fv_seen[phase]) begin
      fv_seen[phase] = 1'b1;
      fv_cyc[phase]  = cyc;
      fv_data[phase] = bus.m_data_out;
    end
    snap_busy[phase]  = busy_out;
    snap_full[phase]  = full_out;
    snap_valid[phase] = bus.m_valid_out;
    snap_len[phase]   = len;
    snap_data[phase]  = bus.m_data_out;

    if (done) begin
      final_checks();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic write(input logic [DATA_W-1:0] d);
    wr_req  = 1'b1;
    wr_data = d;
    step();
    wr_req  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable_in = 1'b0; flush_in = 1'b0; bus.m_ready_in = 1'b0;
    wr_req = 1'b0; wr_data = '0; phase = 0; done = 1'b0; timeout_flag = 1'b0;
    #2497;
    reset = 1'b0; enable_in = 1'b1; phase = 1;
    write(8'h99); write(8'h3C); write(8'hA5);
    idle(10);
    phase = 2; bus.m_ready_in = 1'b1;
    write(8'h0F);
    idle(30);
    phase = 3;
    write(8'h11); write(8'h22);
    idle(5);
    flush_in = 1'b1; step(); flush_in = 1'b0;
    idle(20);
    phase = 4; bus.m_ready_in = 1'b0;
    for (int i = 0; i < 9; i++) write(8'h40 + 8'(i));
    idle(10);
    phase = 5; bus.m_ready_in = 1'b1;
    idle(40);
    phase = 6; bus.m_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) write(8'h50 + 8'(i));
    begin
      int n;
      n = 0;
      while (!(bus.m_valid_out && bus.q_len_in == LEN_W'(5)) && n < 30) begin
        step();
        n++;
      end
      if (n >= 30) timeout_flag = 1'b1;
    end
    idle(2);
    phase = 7; reset = 1'b1;
    idle(3);
    reset = 1'b0; phase = 8; bus.m_ready_in = 1'b1;
    idle(30);
    phase = 9; enable_in = 1'b0;
    for (int i = 0; i < 8; i++) write(8'h60 + 8'(i));
    idle(100);
    phase = 10; enable_in = 1'b1;
    idle(40);
    done = 1'b1;
  end

endmodule
